// File: rtl/reversi_pkg.sv
// reversi_pkg: shared encodings for the board cursor front end.
//   dir_t      - latched move direction (3 bits, DIR_NONE when idle)
//   state_t    - move command FSM state; ST_REPEAT exists only when
//                AUTO_REPEAT_EN is defined
//   BOARD_MAX  - highest row/column index of the board
//   dir_onehot - maps a direction to {down, up, left, right} bit order
package reversi_pkg;

  localparam int BOARD_MAX = 7;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_RIGHT = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_UP    = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1
  } state_t;
`endif

  // Bit 0 right, bit 1 left, bit 2 up, bit 3 down.
  function automatic logic [3:0] dir_onehot(input dir_t d);
    logic [3:0] oh;
    oh = 4'b0000;
    case (d)
      DIR_RIGHT: oh = 4'b0001;
      DIR_LEFT:  oh = 4'b0010;
      DIR_UP:    oh = 4'b0100;
      DIR_DOWN:  oh = 4'b1000;
      default:   oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: conditions one raw asynchronous button.
//   2-FF synchroniser, then a counter that must see the synchronised level
//   differ from the debounced level for DEBOUNCE_CYCLES consecutive cycles
//   before the debounced level flips. rise is a registered one-cycle pulse
//   on each rising edge of the debounced level.
// Ports:
//   clk    in  system clock
//   resetn in  asynchronous active-low reset
//   btn    in  raw button, active-high, asynchronous
//   level  out debounced button level
//   rise   out one-cycle pulse, the cycle after level rises
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          level_d;
  logic [1:0]    fill;
  logic          armed;

  // A button already held when reset is released must not count as a
  // press. 'fill' marks when sync2 carries a genuine sample; the edge
  // detector only arms once the button has been seen released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && !sync2) begin
        armed <= 1'b1;
      end
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
      level_d <= level;
      rise    <= level & ~level_d & armed;
    end
  end

endmodule

// File: rtl/move_cmd_gen.sv
// move_cmd_gen: turns four raw direction buttons into clean single-cycle
// move-enable pulses for the cursor coordinate updater.
// Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat). Without it the
// design emits exactly one pulse per press and REPEAT_DELAY/REPEAT_RATE
// are unused.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   btn_right/left/up/down           raw active-high asynchronous buttons
//   enable                           cursor moves accepted; 0 suppresses pulses
//   moveRightEn/LeftEn/UpEn/DownEn   one-cycle registered move pulses
//   move_valid                       OR of the four move pulses (registered)
// Output protocol: no handshake. A move pulse is high for exactly one clk
// cycle and the consumer must act on it in that cycle; at most one move
// output is high in any cycle and move_valid is high in exactly those
// cycles.
module move_cmd_gen
  import reversi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_right,
  input  logic btn_left,
  input  logic btn_up,
  input  logic btn_down,
  input  logic enable,
  output logic moveRightEn,
  output logic moveLeftEn,
  output logic moveUpEn,
  output logic moveDownEn,
  output logic move_valid
);

  // Degenerate repeat settings are meaningless; this only names them so
  // the parameters stay referenced in the single-pulse build.
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat_cfg
  end

  logic [3:0] raw;
  logic [3:0] level;
  logic [3:0] rise;

  assign raw = {btn_down, btn_up, btn_left, btn_right};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .resetn(resetn),
      .btn   (raw[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  state_t     state;
  dir_t       dir;
  dir_t       pick;
  logic       held;
  logic [3:0] move_q;
  logic       valid_q;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE - 1);
  logic [RCW-1:0] rpt_cnt;
`endif

  // Fixed priority among same-cycle press events: right > left > up > down.
  always_comb begin
    pick = DIR_NONE;
    if (rise[0])      pick = DIR_RIGHT;
    else if (rise[1]) pick = DIR_LEFT;
    else if (rise[2]) pick = DIR_UP;
    else if (rise[3]) pick = DIR_DOWN;
  end

  // Debounced level of the latched button only; other buttons are ignored.
  always_comb begin
    held = |(level & dir_onehot(dir));
  end

  // State advances regardless of enable so a suppressed press is consumed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      dir     <= DIR_NONE;
      move_q  <= 4'b0000;
      valid_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt <= '0;
`endif
    end else begin
      move_q  <= 4'b0000;
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|rise) begin
            dir   <= pick;
            state <= ST_HOLD;
            if (enable) begin
              move_q  <= dir_onehot(pick);
              valid_q <= 1'b1;
            end
`ifdef AUTO_REPEAT_EN
            rpt_cnt <= '0;
`endif
          end
        end
        ST_HOLD: begin
          if (!held) begin
            state <= ST_IDLE;
            dir   <= DIR_NONE;
`ifdef AUTO_REPEAT_EN
            rpt_cnt <= '0;
          end else if (rpt_cnt == DELAY_LAST) begin
            state   <= ST_REPEAT;
            rpt_cnt <= '0;
            if (enable) begin
              move_q  <= dir_onehot(dir);
              valid_q <= 1'b1;
            end
          end else begin
            rpt_cnt <= rpt_cnt + RCW'(1);
`endif
          end
        end
`ifdef AUTO_REPEAT_EN
        ST_REPEAT: begin
          if (!held) begin
            state   <= ST_IDLE;
            dir     <= DIR_NONE;
            rpt_cnt <= '0;
          end else if (rpt_cnt == RATE_LAST) begin
            rpt_cnt <= '0;
            if (enable) begin
              move_q  <= dir_onehot(dir);
              valid_q <= 1'b1;
            end
          end else begin
            rpt_cnt <= rpt_cnt + RCW'(1);
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          dir   <= DIR_NONE;
        end
      endcase
    end
  end

  assign moveRightEn = move_q[0];
  assign moveLeftEn  = move_q[1];
  assign moveUpEn    = move_q[2];
  assign moveDownEn  = move_q[3];
  assign move_valid  = valid_q;

endmodule

// File: doc/move_cmd_gen.md
Name: move_cmd_gen

Overview:
- Front end for the board cursor logic.
- Turns four raw direction buttons into clean, single-cycle move-enable pulses (right/left/up/down) for the coordinate updater.
- Per button: synchronises, debounces and edge-detects. Across buttons: arbitrates simultaneous presses so at most one direction pulses per cycle. Optional hold-to-repeat.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronised input must hold a new level before the debounced state changes (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles a button is held after its first pulse before auto-repeat starts (repeat build only).
- REPEAT_RATE, 5000000, cycles between auto-repeat pulses (repeat build only).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- btn_right  in  1  raw right button, active-high, asynchronous.
- btn_left  in  1  raw left button, active-high, asynchronous.
- btn_up  in  1  raw up button, active-high, asynchronous.
- btn_down  in  1  raw down button, active-high, asynchronous.
- enable  in  1  game accepts cursor moves; when low, pulses are suppressed.
- moveRightEn  out  1  one-cycle right-move pulse.
- moveLeftEn  out  1  one-cycle left-move pulse.
- moveUpEn  out  1  one-cycle up-move pulse.
- moveDownEn  out  1  one-cycle down-move pulse.
- move_valid  out  1  OR of the four move outputs.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, resetn.
- All state is reset by resetn low. Reset values:
  - all move outputs and move_valid 0;
  - synchroniser flops 0; debounced states 0; debounce counters 0;
  - FSM in IDLE; latched direction NONE; repeat counter 0.
- Reset mid-pulse drops the outputs immediately (asynchronously).
- Synchroniser: 2-FF per button.
- Debounce, per button:
  - Counter increments while the synchronised level differs from the debounced state; clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced state flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press event: rising edge of a debounced state.
- Latency: a clean raw press produces its pulse exactly DEBOUNCE_CYCLES+3 clk edges after the first cycle btn is sampled high.
- FSM states: IDLE, HOLD, and (repeat build only) REPEAT.
  - IDLE: on any press event, pick the direction by fixed priority Right > Left > Up > Down. Pulse that output for one cycle (only if enable=1), latch the direction, go to HOLD. Other simultaneous press events are discarded, not queued.
  - HOLD: no pulses. When the latched button's debounced state goes low, go to IDLE.
  - A different button pressed while in HOLD is ignored. A button still held when the FSM returns to IDLE does not fire, since it has no new edge.
- Never more than one move output high in any cycle. Never two pulses in consecutive cycles from a single press.
- enable=0: outputs forced 0; the FSM still advances, so the press is consumed and never replayed when enable rises.
- Output pulses are registered: no combinational path from inputs to outputs.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - HOLD counts up to REPEAT_DELAY-1 while the latched button stays held, then emits a pulse of the latched direction and enters REPEAT.
  - REPEAT emits a pulse every REPEAT_RATE cycles while the button is held.
  - Release in HOLD or REPEAT returns to IDLE and clears the counter.
  - enable=0 gates repeat pulses the same way as first pulses.
- Undefined: no REPEAT state, no repeat counter, one pulse per press. The REPEAT_DELAY and REPEAT_RATE parameters remain but are unused.

Decomposition:
- Package reversi_pkg holds:
  - direction encoding DIR_NONE, DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN (3 bits);
  - FSM state encoding;
  - shared board constant BOARD_MAX = 7.
- One sub-module, button_debounce: 2-FF synchroniser, debounce counter, debounced level and rise-pulse output, parameterised by DEBOUNCE_CYCLES. Instantiate it four times.
- Counter widths derive from $clog2 of the parameters.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
- Hold btn_right high 30 cycles, enable=1 -> moveRightEn high exactly one cycle, 7 edges after first high sample; no further pulses (non-repeat build).
- Glitch btn_up high for 3 cycles -> no output pulse; debounced state stays 0.
- Raise btn_left and btn_down on the same cycle -> only moveLeftEn pulses. After releasing left with down still held -> no moveDownEn pulse.
- Press btn_up with enable=0, then raise enable while still held -> no pulse ever. Release and re-press with enable=1 -> one moveUpEn pulse.
- AUTO_REPEAT_EN build: hold btn_down 60 cycles after its first pulse -> pulses at +0, +20, +28, +36, +44, +52; release -> none.
- Assert resetn low during the moveRightEn pulse cycle -> output drops immediately. After reset is released with the button still held -> no pulse until release and re-press.
